// File: rtl/path_pq_shift.sv
// -----------------------------------------------------------------------------
// path_pq_shift
//
// Shift-register priority queue. It is a chain of DEPTH registered slots, and
// each slot holds {valid, key, value}. Valid slots are always contiguous from
// slot 0, and keys never decrease toward slot DEPTH-1. The smallest key is
// therefore always at the head. The queue accepts one push and/or one pop per
// cycle. Flush clears every slot.
//
// Ports
//   system1000      : clock, rising edge
//   system1000_rst  : asynchronous reset, active-high
//   push_valid      : insert request
//   push_key        : key of entry to insert (unsigned, smaller = first out)
//   push_val        : payload of entry to insert
//   push_ready      : insert accepted this cycle if push_valid
//   pop             : remove head this cycle (ignored when empty)
//   flush           : synchronous clear, overrides push/pop
//   head_valid      : slot 0 holds an entry
//   head_key        : slot 0 key
//   head_val        : slot 0 payload
//   count           : number of valid slots
//   full            : count == DEPTH
//   empty           : count == 0
// -----------------------------------------------------------------------------
module path_pq_shift #(
    parameter int DEPTH = 4,
    parameter int KEY_W = 32,
    parameter int VAL_W = 32,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             system1000,
    input  logic             system1000_rst,
    input  logic             push_valid,
    input  logic [KEY_W-1:0] push_key,
    input  logic [VAL_W-1:0] push_val,
    output logic             push_ready,
    input  logic             pop,
    input  logic             flush,
    output logic             head_valid,
    output logic [KEY_W-1:0] head_key,
    output logic [VAL_W-1:0] head_val,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DEPTH-1:0] slot_v_q,   slot_v_d;
    logic [KEY_W-1:0] slot_key_q [DEPTH];
    logic [KEY_W-1:0] slot_key_d [DEPTH];
    logic [VAL_W-1:0] slot_val_q [DEPTH];
    logic [VAL_W-1:0] slot_val_d [DEPTH];
    logic [CNT_W-1:0] count_q,    count_d;

    // Shifted view: the slot contents after an optional pop. The insert
    // logic always works on this view.
    logic [DEPTH-1:0] view_v;
    logic [KEY_W-1:0] view_key [DEPTH];
    logic [VAL_W-1:0] view_val [DEPTH];

    logic [DEPTH-1:0] place;      // new entry may sit at slot i
    logic [DEPTH-1:0] shift_sel;  // insert point lies strictly below slot i
    logic             full_w;
    logic             empty_w;
    logic             pop_fire;
    logic             push_fire;

    always_comb begin
        full_w     = (count_q == DEPTH_C);
        empty_w    = (count_q == '0);
        pop_fire   = pop && !empty_w;
        push_ready = !full_w || pop_fire;
        push_fire  = push_valid && push_ready;

        for (int i = 0; i < DEPTH - 1; i++) begin
            view_v[i]   = pop_fire ? slot_v_q[i+1]   : slot_v_q[i];
            view_key[i] = pop_fire ? slot_key_q[i+1] : slot_key_q[i];
            view_val[i] = pop_fire ? slot_val_q[i+1] : slot_val_q[i];
        end
        view_v[DEPTH-1]   = pop_fire ? 1'b0 : slot_v_q[DEPTH-1];
        view_key[DEPTH-1] = slot_key_q[DEPTH-1];
        view_val[DEPTH-1] = slot_val_q[DEPTH-1];

        // Strict less-than makes equal keys queue behind existing ones (FIFO
        // among ties). An invalid slot behaves like an infinite key.
        for (int i = 0; i < DEPTH; i++) begin
            place[i] = !view_v[i] || (push_key < view_key[i]);
        end

        // Prefix OR. Only the first set bit of place marks the insert point.
        shift_sel[0] = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            shift_sel[i] = shift_sel[i-1] || place[i-1];
        end

        slot_v_d = view_v;
        for (int i = 0; i < DEPTH; i++) begin
            slot_key_d[i] = view_key[i];
            slot_val_d[i] = view_val[i];
        end

        if (push_fire) begin
            if (place[0]) begin
                slot_v_d[0]   = 1'b1;
                slot_key_d[0] = push_key;
                slot_val_d[0] = push_val;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (shift_sel[i]) begin
                    slot_v_d[i]   = view_v[i-1];
                    slot_key_d[i] = view_key[i-1];
                    slot_val_d[i] = view_val[i-1];
                end else if (place[i]) begin
                    slot_v_d[i]   = 1'b1;
                    slot_key_d[i] = push_key;
                    slot_val_d[i] = push_val;
                end
            end
        end

        count_d = count_q + CNT_W'(push_fire) - CNT_W'(pop_fire);

        if (flush) begin
            slot_v_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            slot_v_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_key_q[i] <= '0;
                slot_val_q[i] <= '0;
            end
        end else begin
            slot_v_q <= slot_v_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                slot_key_q[i] <= slot_key_d[i];
                slot_val_q[i] <= slot_val_d[i];
            end
        end
    end

    assign head_valid = slot_v_q[0];
    assign head_key   = slot_key_q[0];
    assign head_val   = slot_val_q[0];
    assign count      = count_q;
    assign full       = full_w;
    assign empty      = empty_w;

endmodule

// File: tb/tb_path_pq_shift.sv
// -----------------------------------------------------------------------------
// tb_path_pq_shift
//
// Self-checking bench for path_pq_shift with DEPTH=4 and 32-bit keys and
// payloads. A sorted-list reference model predicts the outputs of every
// driven cycle. Predictions and DUT observations go into paired queues.
// Each scenario task compares the queued pairs once its cycles have run.
// -----------------------------------------------------------------------------
module tb_path_pq_shift;

    localparam int DEPTH = 4;
    localparam int KEY_W = 32;
    localparam int VAL_W = 32;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst;
    logic             push_valid;
    logic [KEY_W-1:0] push_key;
    logic [VAL_W-1:0] push_val;
    logic             push_ready;
    logic             pop;
    logic             flush;
    logic             head_valid;
    logic [KEY_W-1:0] head_key;
    logic [VAL_W-1:0] head_val;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] k;
        logic [31:0] v;
    } ent_t;

    typedef struct packed {
        logic        rdy;
        logic        hv;
        logic [31:0] hk;
        logic [31:0] hvl;
        logic [3:0]  cnt;
        logic        full;
        logic        empty;
    } snap_t;

    ent_t  mq[$];
    snap_t expq[$];
    snap_t obsq[$];

    path_pq_shift #(
        .DEPTH(DEPTH), .KEY_W(KEY_W), .VAL_W(VAL_W), .CNT_W(CNT_W)
    ) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .push_valid     (push_valid),
        .push_key       (push_key),
        .push_val       (push_val),
        .push_ready     (push_ready),
        .pop            (pop),
        .flush          (flush),
        .head_valid     (head_valid),
        .head_key       (head_key),
        .head_val       (head_val),
        .count          (count),
        .full           (full),
        .empty          (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation and update the model. Push the model's prediction
    // and the DUT's observation to the scoreboard queues.
    task automatic cycle(input logic pv, input logic [31:0] k, input logic [31:0] v,
                         input logic pp, input logic fl);
        snap_t e;
        snap_t o;
        ent_t  n;
        int    pos;
        logic  pf;
        logic  pr;
        logic  psh;
        @(negedge clk);
        push_valid = pv;
        push_key   = k;
        push_val   = v;
        pop        = pp;
        flush      = fl;
        #1;
        pf  = pp && (mq.size() > 0);
        pr  = (mq.size() < DEPTH) || pf;
        psh = pv && pr;
        e = '0;
        o = '0;
        e.rdy = pr;
        o.rdy = push_ready;
        if (fl) begin
            mq.delete();
        end else begin
            if (pf) void'(mq.pop_front());
            if (psh) begin
                n.k = k;
                n.v = v;
                pos = mq.size();
                for (int i = 0; i < mq.size(); i++) begin
                    if (k < mq[i].k) begin
                        pos = i;
                        break;
                    end
                end
                mq.insert(pos, n);
            end
        end
        e.hv    = (mq.size() > 0);
        e.hk    = e.hv ? mq[0].k : 32'd0;
        e.hvl   = e.hv ? mq[0].v : 32'd0;
        e.cnt   = 4'(mq.size());
        e.full  = (mq.size() == DEPTH);
        e.empty = (mq.size() == 0);
        @(posedge clk);
        #1;
        o.hv    = head_valid;
        o.hk    = e.hv ? head_key : 32'd0;
        o.hvl   = e.hv ? head_val : 32'd0;
        o.cnt   = {1'b0, count};
        o.full  = full;
        o.empty = empty;
        expq.push_back(e);
        obsq.push_back(o);
        push_valid = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({head_valid, head_key, head_val, count, full, empty, push_ready} !==
            {1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL reset_state hv=%b hk=%h hval=%h cnt=%0d full=%b empty=%b rdy=%b required 0/0/0/0/0/1/1",
                     head_valid, head_key, head_val, count, full, empty, push_ready);
        end
    endtask

    task automatic test_sorted_fill;
        snap_t e;
        snap_t o;
        cycle(1'b1, 32'd7, 32'hA, 1'b0, 1'b0);
        cycle(1'b1, 32'd3, 32'hA, 1'b0, 1'b0);
        cycle(1'b1, 32'd9, 32'hA, 1'b0, 1'b0);
        cycle(1'b1, 32'd3, 32'hB, 1'b0, 1'b0);
        checks++;
        if ({count, full, head_key, head_val} !== {3'd4, 1'b1, 32'd3, 32'hA}) begin
            errors++;
            $display("FAIL fill_full cnt=%0d full=%b head=%0d/%h required 4/1/3/a",
                     count, full, head_key, head_val);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL fill_drain_empty empty=%b required 1", empty);
        end
        while (expq.size() > 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL sorted_fill_sb obs=%h exp=%h", o, e);
            end
        end
    endtask

    task automatic test_full_push;
        snap_t e;
        snap_t o;
        cycle(1'b1, 32'd8, 32'h8, 1'b0, 1'b0);
        cycle(1'b1, 32'd2, 32'h2, 1'b0, 1'b0);
        cycle(1'b1, 32'd4, 32'h4, 1'b0, 1'b0);
        cycle(1'b1, 32'd1, 32'h1, 1'b0, 1'b0);
        // Push while full without a pop must be refused.
        cycle(1'b1, 32'd5, 32'h5, 1'b0, 1'b0);
        checks++;
        if ({head_key, count} !== {32'd1, 3'd4}) begin
            errors++;
            $display("FAIL full_refuse head=%0d cnt=%0d required 1/4", head_key, count);
        end
        // Replace: pop the head and push 5 in the same cycle.
        cycle(1'b1, 32'd5, 32'h5, 1'b1, 1'b0);
        checks++;
        if ({head_key, count, full} !== {32'd2, 3'd4, 1'b1}) begin
            errors++;
            $display("FAIL full_replace head=%0d cnt=%0d full=%b required 2/4/1",
                     head_key, count, full);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL full_push_sb obs=%h exp=%h", o, e);
            end
        end
    endtask

    task automatic test_empty_pop;
        snap_t e;
        snap_t o;
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checks++;
        if ({count, head_valid, empty} !== {3'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL empty_pop cnt=%0d hv=%b empty=%b required 0/0/1",
                     count, head_valid, empty);
        end
        cycle(1'b1, 32'd6, 32'h66, 1'b1, 1'b0);
        checks++;
        if ({count, head_valid, head_key} !== {3'd1, 1'b1, 32'd6}) begin
            errors++;
            $display("FAIL empty_pop_push cnt=%0d hv=%b head=%0d required 1/1/6",
                     count, head_valid, head_key);
        end
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL empty_pop_sb obs=%h exp=%h", o, e);
            end
        end
    endtask

    task automatic test_unsigned;
        snap_t e;
        snap_t o;
        cycle(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        cycle(1'b1, 32'h0, 32'h2, 1'b0, 1'b0);
        checks++;
        if (head_key !== 32'h0) begin
            errors++;
            $display("FAIL unsigned_head head=%h required 00000000", head_key);
        end
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checks++;
        if (head_key !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL unsigned_second head=%h required ffffffff", head_key);
        end
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL unsigned_sb obs=%h exp=%h", o, e);
            end
        end
    endtask

    task automatic test_flush;
        snap_t e;
        snap_t o;
        cycle(1'b1, 32'd10, 32'h1, 1'b0, 1'b0);
        cycle(1'b1, 32'd20, 32'h2, 1'b0, 1'b0);
        cycle(1'b1, 32'd30, 32'h3, 1'b0, 1'b0);
        cycle(1'b1, 32'd5, 32'h4, 1'b1, 1'b1);
        checks++;
        if ({count, empty, head_valid} !== {3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL flush_clear cnt=%0d empty=%b hv=%b required 0/1/0",
                     count, empty, head_valid);
        end
        while (expq.size() > 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL flush_sb obs=%h exp=%h", o, e);
            end
        end
    endtask

    task automatic test_async_reset;
        snap_t e;
        snap_t o;
        cycle(1'b1, 32'd4, 32'h1, 1'b0, 1'b0);
        cycle(1'b1, 32'd2, 32'h2, 1'b0, 1'b0);
        cycle(1'b1, 32'd6, 32'h3, 1'b0, 1'b0);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL async_pre_sb obs=%h exp=%h", o, e);
            end
        end
        // Assert the reset between clock edges. The outputs must clear
        // before the next rising edge arrives.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({head_valid, head_key, head_val, count, full, empty, push_ready} !==
            {1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL async_reset hv=%b hk=%h hval=%h cnt=%0d full=%b empty=%b rdy=%b required 0/0/0/0/0/1/1",
                     head_valid, head_key, head_val, count, full, empty, push_ready);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        mq.delete();
        cycle(1'b1, 32'd9, 32'h9, 1'b0, 1'b0);
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL async_post_sb obs=%h exp=%h", o, e);
            end
        end
    endtask

    task automatic test_random;
        snap_t       e;
        snap_t       o;
        logic        pv;
        logic        pp;
        logic        fl;
        logic [31:0] k;
        for (int n = 0; n < 10000; n++) begin
            pv = ($urandom_range(0, 99) < 60);
            pp = ($urandom_range(0, 99) < 45);
            fl = ($urandom_range(0, 99) < 2);
            k  = ($urandom_range(0, 31) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 7));
            cycle(pv, k, 32'(n), pp, fl);
        end
        while (expq.size() > 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL random_sb obs=%h exp=%h", o, e);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        push_valid = 1'b0;
        push_key   = '0;
        push_val   = '0;
        pop        = 1'b0;
        flush      = 1'b0;
        #12;
        rst = 1'b0;
        #1;
        test_reset();
        test_sorted_fill();
        test_full_push();
        test_empty_pop();
        test_unsigned();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
